circuit1_hlsm: RTL and testbench
================================

Name: circuit1_hlsm

Overview:
- Multi-cycle, resource-shared, scheduled implementation of the circuit1 dataflow, with an FSM sequencing a single shared adder.
- Computes d=a+b, e=a+c, f=a*c, g=(d>e), x=f-d, z=g?e:d.
- Uses a Start/Done handshake and is the controller + datapath template for the team's HLSM-style scheduled circuits.
- Sits wherever circuit1 is used when area is preferred over single-cycle throughput.

Parameters:
- DATAWIDTH, 16, width of a, b, c, z, x and all internal values.

Ports:
- Clk  input  1  system clock, rising edge.
- Rst  input  1  asynchronous, active-low reset (Rst=0 resets immediately; release is synchronous to Clk by the integrator).
- Start  input  1  request; sampled only in state WAIT.
- a  input  DATAWIDTH  operand a.
- b  input  DATAWIDTH  operand b.
- c  input  DATAWIDTH  operand c.
- z  output  DATAWIDTH  registered result z.
- x  output  DATAWIDTH  registered result x.
- Done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (Rst=0, any state): state=WAIT; z=0, x=0, Done=0; internal regs ra, rb, rc, d, e, f cleared. Mid-operation reset abandons the computation; outputs do not update.
- States: WAIT, S1, S2, S3, FINAL. Encoding is free.
- WAIT:
  - If Start=1 at the edge, capture ra=a, rb=b, rc=c and go to S1.
  - Otherwise stay. Inputs are not sampled again until the next WAIT.
- S1: d <= ra+rb (shared adder); f <= ra*rc (low DATAWIDTH bits). Go to S2.
- S2: e <= ra+rc (shared adder, second use); d and f held. Go to S3.
- S3: g = (d > e) combinational. z <= g ? e : d; x <= f - d. Go to FINAL.
- FINAL: Done=1. Unconditionally go to WAIT.
- Done is 0 in every other state.
- Latency: Done is high for exactly one cycle, starting 3 edges after the edge that sampled Start. z and x change only at the S3->FINAL edge.
- Throughput: one result per 5 cycles when Start is held high. Start sampled in WAIT, then S1, S2, S3, FINAL.
- Start is ignored in S1, S2, S3 and FINAL; it is not queued.
- Changes on a, b, c after capture have no effect on the result.
- Arithmetic:
  - All operations are unsigned modulo 2^DATAWIDTH.
  - Adder carry-out is discarded.
  - Multiplier keeps the low DATAWIDTH bits.
  - Subtract wraps.
  - Compare is strict greater-than; equality gives g=0, so z=d.
- z and x hold their last value until the next completion or reset.
- Exactly one adder instance exists; its operand muxing is driven by the FSM state.

Optional Feature:
- Macro CIRCUIT1_HLSM_SIGNED_EN.
- Defined: the comparison g treats d and e as two's-complement signed. Add, multiply (low bits) and subtract results are bit-identical to the unsigned case.
- Not defined: the comparison is unsigned.
- Timing and ports are identical in both builds.

Test Plan:
- Assert Rst=0 mid-S2 with Clk running -> immediately z=0, x=0, Done=0. After release with Start=0, the block stays in WAIT and Done stays 0.
- a=3, b=5, c=2, Start pulse -> d=8, e=5, f=6, g=1. Three edges later Done=1 for one cycle with z=0x0005, x=0xFFFE.
- a=2, b=1, c=7 -> z=0x0003 (g=0), x=0x000B. Also apply equal case a=4, b=c=9 -> z=0x000D (d), x=0x0017.
- a=0xFFFF, b=2, c=0xFFFF:
  - Default build: z=0x0001, x=0x0000.
  - CIRCUIT1_HLSM_SIGNED_EN build: z=0xFFFE, x=0x0000 (1 > -2).
- Start held high continuously with operands changed every cycle -> Done every 5th cycle. Each result matches the operands present at the WAIT sampling edge; operands changed during S1–FINAL are ignored.
- Pulse Start during S2 -> no extra operation; exactly one Done.

Source files
------------

// File: rtl/circuit1_hlsm.sv
// circuit1_hlsm: multi-cycle, resource-shared implementation of the circuit1
// dataflow (d=a+b, e=a+c, f=a*c, g=(d>e), x=f-d, z=g?e:d).
// One adder is time-shared between S1 (d) and S2 (e), with its operands
// selected by the FSM state.
//
// Optional build macro: CIRCUIT1_HLSM_SIGNED_EN
//   defined     -> comparison g treats d and e as two's-complement signed
//   not defined -> comparison g is unsigned
//   Add, multiply and subtract results are identical in both builds.
//
// Ports:
//   Clk    in   system clock, rising edge
//   Rst    in   asynchronous active-low reset
//   Start  in   request, sampled only in WAIT
//   a,b,c  in   DATAWIDTH operands, captured on the Start edge
//   z, x   out  registered results, updated only on the S3->FINAL edge
//   Done   out  registered one-cycle completion pulse (high in FINAL)

module circuit1_hlsm #(
    parameter int unsigned DATAWIDTH = 16
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 Start,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    input  logic [DATAWIDTH-1:0] c,
    output logic [DATAWIDTH-1:0] z,
    output logic [DATAWIDTH-1:0] x,
    output logic                 Done
);

    typedef enum logic [2:0] {
        ST_WAIT  = 3'd0,
        ST_S1    = 3'd1,
        ST_S2    = 3'd2,
        ST_S3    = 3'd3,
        ST_FINAL = 3'd4
    } state_t;

    state_t state;

    logic [DATAWIDTH-1:0] ra;
    logic [DATAWIDTH-1:0] rb;
    logic [DATAWIDTH-1:0] rc;
    logic [DATAWIDTH-1:0] d;
    logic [DATAWIDTH-1:0] e;
    logic [DATAWIDTH-1:0] f;

    logic [DATAWIDTH-1:0] add_b;
    logic [DATAWIDTH-1:0] sum;
    logic [DATAWIDTH-1:0] prod_lo;
    logic                 g;

    // Shared adder: second operand is rb in S1 (d) and rc in S2 (e).
    always_comb begin
        add_b = rb;
        if (state == ST_S2) begin
            add_b = rc;
        end
        sum = ra + add_b;
    end

    // Low DATAWIDTH bits of the product; the high half is never needed.
    assign prod_lo = ra * rc;

    // Strict greater-than; equality selects d.
`ifdef CIRCUIT1_HLSM_SIGNED_EN
    assign g = ($signed(d) > $signed(e));
`else
    assign g = (d > e);
`endif

    // Controller and datapath registers.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= ST_WAIT;
            ra    <= '0;
            rb    <= '0;
            rc    <= '0;
            d     <= '0;
            e     <= '0;
            f     <= '0;
            z     <= '0;
            x     <= '0;
            Done  <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                ST_WAIT: begin
                    if (Start) begin
                        ra    <= a;
                        rb    <= b;
                        rc    <= c;
                        state <= ST_S1;
                    end
                end
                ST_S1: begin
                    d     <= sum;
                    f     <= prod_lo;
                    state <= ST_S2;
                end
                ST_S2: begin
                    e     <= sum;
                    state <= ST_S3;
                end
                ST_S3: begin
                    z     <= g ? e : d;
                    x     <= f - d;
                    Done  <= 1'b1;
                    state <= ST_FINAL;
                end
                ST_FINAL: begin
                    state <= ST_WAIT;
                end
                default: begin
                    state <= ST_WAIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_circuit1_hlsm.sv
// tb_circuit1_hlsm: scoreboard bench for circuit1_hlsm. Stimulus pushes the
// expected {z, x} when it issues a request; a monitor pops and compares on
// every Done pulse.

module tb_circuit1_hlsm;

    localparam int unsigned W = 16;

    typedef struct packed {
        logic [W-1:0] z;
        logic [W-1:0] x;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    logic [W-1:0] z;
    logic [W-1:0] x;
    logic         done;

    exp_t q[$];
    exp_t exp_v;
    int   checks     = 0;
    int   failures   = 0;
    int   done_count = 0;

    circuit1_hlsm #(.DATAWIDTH(W)) dut (
        .Clk   (clk),
        .Rst   (rst),
        .Start (start),
        .a     (a),
        .b     (b),
        .c     (c),
        .z     (z),
        .x     (x),
        .Done  (done)
    );

    always #5 clk = ~clk;

    // Reference model of the dataflow, used for the streaming operands.
    function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                   input logic [W-1:0] ic);
        logic [W-1:0] md;
        logic [W-1:0] me;
        logic [W-1:0] mf;
        logic         mg;
        exp_t         r;
        md = ia + ib;
        me = ia + ic;
        mf = ia * ic;
`ifdef CIRCUIT1_HLSM_SIGNED_EN
        mg = ($signed(md) > $signed(me));
`else
        mg = (md > me);
`endif
        r.z = mg ? me : md;
        r.x = mf - md;
        return r;
    endfunction

    // Monitor: every Done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst && done) begin
            done_count++;
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_done z=%h x=%h with empty scoreboard", z, x);
            end else begin
                exp_v = q.pop_front();
                if (z !== exp_v.z || x !== exp_v.x) begin
                    failures++;
                    $display("FAIL result got z=%h x=%h expected z=%h x=%h",
                             z, x, exp_v.z, exp_v.x);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s got %h expected %h", name, act, req);
        end
    endtask

    // Present operands with Start for one sampling edge, then scramble them.
    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic [W-1:0] ic, input exp_t ex);
        @(negedge clk);
        a = ia;
        b = ib;
        c = ic;
        start = 1'b1;
        q.push_back(ex);
        @(posedge clk);
        #1;
        start = 1'b0;
        a = 16'hDEAD;
        b = 16'hBEEF;
        c = 16'h1234;
    endtask

    // Done must rise 3 edges after the sampling edge and last one cycle.
    task automatic wait_done(input string name);
        int n;
        bit seen;
        seen = 1'b0;
        for (n = 1; n <= 8; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen || n != 3) begin
            failures++;
            $display("FAIL %s_latency got %0d edges expected 3", name, seen ? n : -1);
        end
        if (seen) begin
            @(posedge clk);
            #1;
            chk({name, "_pulse_width"}, W'(done), W'(0));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc0;
        rst   = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        c     = '0;
        #12;
        chk("reset_z", z, W'(0));
        chk("reset_x", x, W'(0));
        chk("reset_done", W'(done), W'(0));
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // d=8 e=5 f=6 g=1
        issue(16'd3, 16'd5, 16'd2, '{z: 16'h0005, x: 16'hFFFE});
        wait_done("v1");

        // Reset mid-S2 abandons the operation and clears the outputs at once.
        issue(16'd2, 16'd1, 16'd7, '{z: 16'h0003, x: 16'h000B});
        @(posedge clk);
        #3;
        rst = 1'b0;
        q.delete();
        #1;
        chk("midreset_z", z, W'(0));
        chk("midreset_x", x, W'(0));
        chk("midreset_done", W'(done), W'(0));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            chk("idle_done", W'(done), W'(0));
        end
        chk("idle_z", z, W'(0));

        // d=3 e=9 g=0
        issue(16'd2, 16'd1, 16'd7, '{z: 16'h0003, x: 16'h000B});
        wait_done("v2");
        // Equal d and e select d
        issue(16'd4, 16'd9, 16'd9, '{z: 16'h000D, x: 16'h0017});
        wait_done("v3");
        // d=1 e=0xFFFE f=1
`ifdef CIRCUIT1_HLSM_SIGNED_EN
        issue(16'hFFFF, 16'd2, 16'hFFFF, '{z: 16'hFFFE, x: 16'h0000});
`else
        issue(16'hFFFF, 16'd2, 16'hFFFF, '{z: 16'h0001, x: 16'h0000});
`endif
        wait_done("v4");

        // Start pulsed during S2 must not queue a second operation.
        dc0 = done_count;
        issue(16'd1, 16'd1, 16'd1, '{z: 16'h0002, x: 16'hFFFF});
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("s2_pulse_done_count", W'(done_count - dc0), W'(1));

        // Start held high, operands change every cycle; samples at k%5==0.
        dc0 = done_count;
        @(negedge clk);
        start = 1'b1;
        for (int k = 0; k < 15; k++) begin
            a = W'(k * 1021 + 3);
            b = W'(k * 77 + 500);
            c = W'(k * 4099 + 9);
            if (k % 5 == 0) q.push_back(model(a, b, c));
            @(posedge clk);
            #1;
            chk("stream_done", W'(done), W'((k % 5) == 3));
        end
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("stream_done_count", W'(done_count - dc0), W'(3));
        chk("scoreboard_empty", W'(q.size()), W'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
